// File: rtl/ip_tx.sv
// IPv4 transmit framer: latches addresses and length, computes the header checksum over 11 cycles,
// then emits the 20-byte header followed seamlessly by the forwarded UDP bytes; the MAC paces start via ip_data_req.
module ip_tx #(
  parameter logic [7:0] TTL   = 8'h80,
  parameter logic [7:0] PROTO = 8'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] source_ip_addr,
  input  logic [31:0] destination_ip_addr,
  input  logic [15:0] udp_send_data_length,
  input  logic        ip_tx_req,
  input  logic        ip_data_req,
  output logic        ip_tx_ready,
  output logic [7:0]  ip_tx_data,
  output logic        ip_tx_last,
  output logic        ip_tx_err,
  output logic        udp_tx_req,
  input  logic        udp_tx_ready,
  output logic        udp_data_req,
  input  logic [7:0]  udp_tx_data
);

  typedef enum logic [1:0] {IDLE, CHECKSUM, SEND_WAIT, IP_SEND} state_t;

  state_t      state;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] ip_len;
  logic [15:0] udp_fwd;
  logic [15:0] ident;
  logic [15:0] id_r;
  logic [31:0] sum;
  logic [3:0]  ck_cnt;
  logic [15:0] tmo;
  logic [15:0] cnt;

  logic [15:0] pay8;
  logic [15:0] fwd_calc;
  logic [15:0] ck_word;
  logic [15:0] cks;
  logic [7:0]  hdr_byte;

  // UDP datagrams shorter than the Ethernet minimum are padded out to 26 bytes
  assign pay8     = udp_send_data_length + 16'd8;
  assign fwd_calc = (pay8 < 16'd26) ? 16'd26 : pay8;
  assign cks      = ~sum[15:0];

  always_comb begin
    ck_word = 16'h0000;
    case (ck_cnt)
      4'd0:    ck_word = 16'h4500;
      4'd1:    ck_word = ip_len;
      4'd2:    ck_word = id_r;
      4'd3:    ck_word = 16'h4000;
      4'd4:    ck_word = {TTL, PROTO};
      4'd5:    ck_word = src_r[31:16];
      4'd6:    ck_word = src_r[15:0];
      4'd7:    ck_word = dst_r[31:16];
      4'd8:    ck_word = dst_r[15:0];
      default: ck_word = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (cnt[4:0])
      5'd0:    hdr_byte = 8'h45;
      5'd1:    hdr_byte = 8'h00;
      5'd2:    hdr_byte = ip_len[15:8];
      5'd3:    hdr_byte = ip_len[7:0];
      5'd4:    hdr_byte = id_r[15:8];
      5'd5:    hdr_byte = id_r[7:0];
      5'd6:    hdr_byte = 8'h40;
      5'd7:    hdr_byte = 8'h00;
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = PROTO;
      5'd10:   hdr_byte = cks[15:8];
      5'd11:   hdr_byte = cks[7:0];
      5'd12:   hdr_byte = src_r[31:24];
      5'd13:   hdr_byte = src_r[23:16];
      5'd14:   hdr_byte = src_r[15:8];
      5'd15:   hdr_byte = src_r[7:0];
      5'd16:   hdr_byte = dst_r[31:24];
      5'd17:   hdr_byte = dst_r[23:16];
      5'd18:   hdr_byte = dst_r[15:8];
      5'd19:   hdr_byte = dst_r[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src_r        <= 32'h0;
      dst_r        <= 32'h0;
      ip_len       <= 16'h0;
      udp_fwd      <= 16'h0;
      ident        <= 16'h0;
      id_r         <= 16'h0;
      sum          <= 32'h0;
      ck_cnt       <= 4'h0;
      tmo          <= 16'h0;
      cnt          <= 16'h0;
      ip_tx_ready  <= 1'b0;
      ip_tx_data   <= 8'h00;
      ip_tx_last   <= 1'b0;
      ip_tx_err    <= 1'b0;
      udp_tx_req   <= 1'b0;
      udp_data_req <= 1'b0;
    end else begin
      ip_tx_err    <= 1'b0;
      udp_tx_req   <= 1'b0;
      udp_data_req <= 1'b0;
      case (state)
        IDLE: begin
          ip_tx_ready <= 1'b0;
          ip_tx_data  <= 8'h00;
          ip_tx_last  <= 1'b0;
          if (ip_tx_req) begin
            src_r   <= source_ip_addr;
            dst_r   <= destination_ip_addr;
            ip_len  <= udp_send_data_length + 16'd28;
            udp_fwd <= fwd_calc;
            id_r    <= ident;
            sum     <= 32'h0;
            ck_cnt  <= 4'h0;
            state   <= CHECKSUM;
          end
        end
        CHECKSUM: begin
          if (ck_cnt < 4'd9)
            sum <= sum + {16'h0000, ck_word};
          else
            sum <= {15'h0000, {1'b0, sum[15:0]} + {1'b0, sum[31:16]}};
          ck_cnt <= ck_cnt + 4'd1;
          if (ck_cnt == 4'd10) begin
            tmo   <= 16'h0;
            state <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          ip_tx_ready <= 1'b1;
          if (ip_data_req) begin
            ip_tx_ready <= 1'b0;
            udp_tx_req  <= 1'b1;
            ident       <= ident + 16'd1;
            cnt         <= 16'h0;
            state       <= IP_SEND;
          end else if (tmo == 16'hffff) begin
            ip_tx_ready <= 1'b0;
            ip_tx_err   <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        IP_SEND: begin
          cnt <= cnt + 16'd1;
          if (ip_tx_last) begin
            // last byte is on the wire this cycle; requests are ignored until IDLE
            ip_tx_last <= 1'b0;
            ip_tx_data <= 8'h00;
            state      <= IDLE;
          end else if (udp_data_req && !udp_tx_ready) begin
            ip_tx_err  <= 1'b1;
            ip_tx_data <= 8'h00;
            state      <= IDLE;
          end else begin
            ip_tx_data <= (cnt < 16'd20) ? hdr_byte : udp_tx_data;
            // UDP byte 0 lands two cycles after the request, right behind header byte 19
            if (cnt == 16'd17)
              udp_data_req <= 1'b1;
            if (cnt == 16'd19 + udp_fwd)
              ip_tx_last <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx.sv
// Randomized bench for ip_tx: a reference model builds each expected datagram from the field rules
// and a UDP-stage emulator answers udp_data_req; every observed cycle is compared against the model.
module tb_ip_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] source_ip_addr;
  logic [31:0] destination_ip_addr;
  logic [15:0] udp_send_data_length;
  logic        ip_tx_req;
  logic        ip_data_req;
  logic        ip_tx_ready;
  logic [7:0]  ip_tx_data;
  logic        ip_tx_last;
  logic        ip_tx_err;
  logic        udp_tx_req;
  logic        udp_tx_ready;
  logic        udp_data_req;
  logic [7:0]  udp_tx_data;

  ip_tx dut (
    .clk                  (clk),
    .rst                  (rst),
    .source_ip_addr       (source_ip_addr),
    .destination_ip_addr  (destination_ip_addr),
    .udp_send_data_length (udp_send_data_length),
    .ip_tx_req            (ip_tx_req),
    .ip_data_req          (ip_data_req),
    .ip_tx_ready          (ip_tx_ready),
    .ip_tx_data           (ip_tx_data),
    .ip_tx_last           (ip_tx_last),
    .ip_tx_err            (ip_tx_err),
    .udp_tx_req           (udp_tx_req),
    .udp_tx_ready         (udp_tx_ready),
    .udp_data_req         (udp_data_req),
    .udp_tx_data          (udp_tx_data)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_id;
  logic [7:0]  obs_hdr [20];

  localparam int MODE_NORMAL  = 0;
  localparam int MODE_ABORT   = 1;
  localparam int MODE_TIMEOUT = 2;
  localparam int MODE_RESET   = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One's-complement sum over the ten header words with the checksum field as zero
  function automatic logic [15:0] ref_cks(input logic [31:0] s, input logic [31:0] d,
                                          input logic [15:0] len, input logic [15:0] id);
    logic [15:0] w [10];
    int unsigned acc;
    w = '{16'h4500, len, id, 16'h4000, 16'h8011, s[31:16], s[15:0], d[31:16], d[15:0], 16'h0000};
    acc = 0;
    for (int i = 0; i < 10; i++) acc += {16'h0000, w[i]};
    while (acc > 32'h0000ffff) acc = (acc & 32'h0000ffff) + (acc >> 16);
    return ~acc[15:0];
  endfunction

  task automatic run_pkt(input logic [31:0] s, input logic [31:0] d, input logic [15:0] pay,
                         input int mode, input int gap);
    logic [7:0]  hdr [20];
    logic [7:0]  udp [$];
    logic [15:0] len;
    logic [15:0] c;
    logic [7:0]  e_data;
    logic        e_last, e_udr, e_err;
    int          fwd, ds, k;

    len = pay + 16'd28;
    fwd = int'(pay) + 8;
    if (fwd < 26) fwd = 26;
    c = ref_cks(s, d, len, exp_id);
    hdr = '{8'h45, 8'h00, len[15:8], len[7:0], exp_id[15:8], exp_id[7:0], 8'h40, 8'h00,
            8'h80, 8'h11, c[15:8], c[7:0], s[31:24], s[23:16], s[15:8], s[7:0],
            d[31:24], d[23:16], d[15:8], d[7:0]};
    udp = {};
    for (int i = 0; i < fwd; i++) udp.push_back(8'($urandom));

    source_ip_addr       = s;
    destination_ip_addr  = d;
    udp_send_data_length = pay;
    ip_tx_req            = 1'b1;
    @(negedge clk);
    ip_tx_req            = 1'b0;
    source_ip_addr       = $urandom;
    destination_ip_addr  = $urandom;
    udp_send_data_length = 16'($urandom);
    repeat (11) @(negedge clk);
    chk("ready_at_r12", {31'h0, ip_tx_ready}, 32'h0);
    @(negedge clk);
    chk("ready_at_r13", {31'h0, ip_tx_ready}, 32'h1);

    if (mode == MODE_TIMEOUT) begin
      k = 13;
      while (!ip_tx_err && k < 70000) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_cycle", k, 65548);
      chk("timeout_ready", {31'h0, ip_tx_ready}, 32'h0);
      @(negedge clk);
      chk("timeout_err_pulse", {31'h0, ip_tx_err}, 32'h0);
      return;
    end

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("ready_hold", {31'h0, ip_tx_ready}, 32'h1);
    end
    ip_data_req = 1'b1;
    @(negedge clk);
    ip_data_req = 1'b0;
    exp_id++;
    chk("start_t1", {30'h0, ip_tx_ready, udp_tx_req}, 32'h1);
    if (mode == MODE_ABORT) udp_tx_ready = 1'b0;

    ds = -1;
    for (k = 2; k <= 22 + fwd; k++) begin
      @(negedge clk);
      if (mode == MODE_ABORT && k >= 20) begin
        e_err = (k == 20); e_data = 8'h00; e_last = 1'b0; e_udr = 1'b0;
      end else begin
        e_err  = 1'b0;
        e_udr  = (k == 19);
        e_last = (k == 21 + fwd);
        if (k <= 21)            e_data = hdr[k-2];
        else if (k <= 21 + fwd) e_data = udp[k-22];
        else                    e_data = 8'h00;
      end
      if (k <= 21) obs_hdr[k-2] = ip_tx_data;
      chk($sformatf("stream_k%0d", k),
          {19'h0, ip_tx_ready, udp_tx_req, ip_tx_err, ip_tx_last, udp_data_req, ip_tx_data},
          {19'h0, 1'b0, 1'b0, e_err, e_last, e_udr, e_data});
      if (mode == MODE_ABORT && k == 21) break;
      if (mode == MODE_RESET && k == 8) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_id = 16'h0;
        chk("reset_mid_outputs",
            {19'h0, ip_tx_ready, udp_tx_req, ip_tx_err, ip_tx_last, udp_data_req, ip_tx_data}, 32'h0);
        return;
      end
      // UDP stage: byte j must be valid two cycles after the observed udp_data_req, plus j
      if (udp_data_req && ds < 0) ds = k;
      if (ds >= 0 && k - ds - 2 >= 0 && k - ds - 2 < fwd) udp_tx_data = udp[k-ds-2];
      else                                                 udp_tx_data = 8'($urandom);
    end
    udp_tx_ready = 1'b1;
  endtask

  initial begin
    rst                  = 1'b1;
    source_ip_addr       = 32'h0;
    destination_ip_addr  = 32'h0;
    udp_send_data_length = 16'h0;
    ip_tx_req            = 1'b0;
    ip_data_req          = 1'b0;
    udp_tx_ready         = 1'b1;
    udp_tx_data          = 8'h00;
    exp_id               = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {19'h0, ip_tx_ready, udp_tx_req, ip_tx_err, ip_tx_last, udp_data_req, ip_tx_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_pkt(32'hC0A8010A, 32'hC0A80164, 16'd18, MODE_NORMAL, 0);
    chk("vec1_cks", {16'h0, obs_hdr[10], obs_hdr[11]}, 32'h7700);
    chk("vec1_len", {16'h0, obs_hdr[2], obs_hdr[3]}, 32'h002E);
    chk("vec1_id", {16'h0, obs_hdr[4], obs_hdr[5]}, 32'h0000);
    run_pkt(32'hC0A8010A, 32'hC0A80164, 16'd18, MODE_NORMAL, 2);
    chk("vec2_cks", {16'h0, obs_hdr[10], obs_hdr[11]}, 32'h76FF);
    chk("vec2_id", {16'h0, obs_hdr[4], obs_hdr[5]}, 32'h0001);
    run_pkt(32'hC0A8010A, 32'hC0A80164, 16'd4, MODE_NORMAL, 1);
    chk("pad_len", {16'h0, obs_hdr[2], obs_hdr[3]}, 32'h0020);
    run_pkt(32'hC0A8010A, 32'hC0A80164, 16'd100, MODE_NORMAL, 0);
    chk("long_len", {16'h0, obs_hdr[2], obs_hdr[3]}, 32'h0080);

    run_pkt(32'h0A000001, 32'h0A000002, 16'd30, MODE_TIMEOUT, 0);
    run_pkt(32'h0A000001, 32'h0A000002, 16'd30, MODE_NORMAL, 0);
    chk("id_after_timeout", {16'h0, obs_hdr[4], obs_hdr[5]}, 32'h0004);

    run_pkt(32'h0A000003, 32'h0A000004, 16'd40, MODE_ABORT, 1);
    run_pkt(32'h0A000003, 32'h0A000004, 16'd12, MODE_NORMAL, 0);

    run_pkt(32'hAC100001, 32'hAC100002, 16'd50, MODE_RESET, 0);
    run_pkt(32'hAC100001, 32'hAC100002, 16'd20, MODE_NORMAL, 0);
    chk("id_after_reset", {16'h0, obs_hdr[4], obs_hdr[5]}, 32'h0000);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pkt($urandom, $urandom, 16'($urandom_range(0, 150)), MODE_NORMAL, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
